// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared types and constants for the UART receive front end.
//   state_t           - receiver state encoding (also exported as a debug output)
//   PERR / FERR / BRK - status bit positions inside the FIFO word
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } state_t;

    localparam int PERR = 8;
    localparam int FERR = 9;
    localparam int BRK  = 10;

endpackage

// File: rtl/uart_rx_fifo_writer_if.sv
// uart_rx_fifo_writer_if: write side of the RX FIFO.
//   fifo_wr_data - character word (status in bits 10:8)
//   fifo_wr_en   - one-cycle write strobe
//   fifo_wr_full - FIFO full flag
// Handshake: fifo_wr_en acts as valid and !fifo_wr_full as ready. The master
// samples fifo_wr_full in the cycle it decides a character; if the FIFO is not
// full it raises fifo_wr_en for exactly one cycle on the following cycle with
// fifo_wr_data valid alongside it, otherwise the character is dropped. There is
// no stalling: a word offered is always taken, a word refused is lost.
interface uart_rx_fifo_writer_if #(
    parameter int c_FIFO_DATA_WIDTH = 32
);
    logic [c_FIFO_DATA_WIDTH-1:0] fifo_wr_data;
    logic                         fifo_wr_en;
    logic                         fifo_wr_full;

    modport master (output fifo_wr_data, output fifo_wr_en, input fifo_wr_full);
    modport slave  (input fifo_wr_data, input fifo_wr_en, output fifo_wr_full);
endinterface

// File: rtl/uart_rx_tick_gen.sv
// uart_rx_tick_gen: reloadable baud divider producing the oversample tick.
//   clk, rst - clock and asynchronous active-high reset
//   restart  - synchronous restart: latch div and start a fresh tick period
//   div      - cycles per tick minus 1, sampled only on restart
//   tick     - one-cycle pulse every div+1 cycles after a restart
module uart_rx_tick_gen #(
    parameter int c_DIV_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   restart,
    input  logic [c_DIV_WIDTH-1:0] div,
    output logic                   tick
);

    logic [c_DIV_WIDTH-1:0] div_q;
    logic [c_DIV_WIDTH-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= '0;
            cnt   <= '0;
        end else if (restart) begin
            div_q <= div;
            cnt   <= div;
        end else if (cnt == '0) begin
            cnt <= div_q;
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

    // Suppressed during restart so the first tick of a frame is a full period
    // after the start edge.
    assign tick = (cnt == '0) && !restart;

endmodule

// File: rtl/uart_rx_fifo_writer.sv
// uart_rx_fifo_writer: UART receiver that writes one word per character into
// the RX FIFO.
//   wr_clk, wr_rst        - clock and asynchronous active-high reset
//   rx_in                 - asynchronous serial line, idles high
//   baud_div              - wr_clk cycles per oversample tick minus 1
//   parity_en, parity_odd - parity configuration (latched at start of frame)
//   fifo                  - FIFO write port (data, strobe, full)
//   overrun, ovr_clr      - sticky dropped-character flag and its clear
//   rx_busy               - receiver is inside a frame
//   state_dbg             - current receiver state
module uart_rx_fifo_writer
    import uart_rx_pkg::*;
#(
    parameter int c_OVERSAMPLE      = 16,
    parameter int c_DATA_BITS       = 8,
    parameter int c_DIV_WIDTH       = 16,
    parameter int c_FIFO_DATA_WIDTH = 32
) (
    input  logic                   wr_clk,
    input  logic                   wr_rst,
    input  logic                   rx_in,
    input  logic [c_DIV_WIDTH-1:0] baud_div,
    input  logic                   parity_en,
    input  logic                   parity_odd,
    uart_rx_fifo_writer_if.master  fifo,
    output logic                   overrun,
    input  logic                   ovr_clr,
    output logic                   rx_busy,
    output state_t                 state_dbg
);

    localparam int SCNT_W = $clog2(c_OVERSAMPLE);
    localparam int MID    = c_OVERSAMPLE / 2;

    state_t                       state;
    logic                         rx_meta, rxs, rxs_prev;
    logic                         tick, start_edge;
    logic [SCNT_W-1:0]            scnt;
    logic [2:0]                   bcnt;
    logic [c_DATA_BITS-1:0]       data_q;
    logic                         samp_a, samp_b, samp_bit, decide;
    logic                         pen_q, podd_q, pbit, perr;
    logic                         drop;
    logic [c_FIFO_DATA_WIDTH-1:0] word;

    // Two-flop synchronizer plus one history flop for falling-edge detection;
    // all reset to the idle (high) level so reset release never looks like a start.
    always_ff @(posedge wr_clk or posedge wr_rst) begin
        if (wr_rst) begin
            rx_meta  <= 1'b1;
            rxs      <= 1'b1;
            rxs_prev <= 1'b1;
        end else begin
            rx_meta  <= rx_in;
            rxs      <= rx_meta;
            rxs_prev <= rxs;
        end
    end

    assign start_edge = (state == IDLE) && rxs_prev && !rxs;

    uart_rx_tick_gen #(.c_DIV_WIDTH(c_DIV_WIDTH)) u_tick_gen (
        .clk     (wr_clk),
        .rst     (wr_rst),
        .restart (start_edge),
        .div     (baud_div),
        .tick    (tick)
    );

    // Majority vote of ticks MID-1, MID and MID+1; the third sample is the live line.
    assign decide   = tick && (scnt == SCNT_W'(MID + 1));
    assign samp_bit = (samp_a & samp_b) | (samp_a & rxs) | (samp_b & rxs);
    assign drop     = (state == STOP) && decide && fifo.fifo_wr_full;

    always_comb begin
        word                   = '0;
        word[c_DATA_BITS-1:0]  = data_q;
        word[PERR]             = perr;
        word[FERR]             = !samp_bit;
        word[BRK]              = !samp_bit && (data_q == '0) && (!pen_q || !pbit);
    end

    always_ff @(posedge wr_clk or posedge wr_rst) begin
        if (wr_rst) begin
            state             <= IDLE;
            scnt              <= '0;
            bcnt              <= '0;
            data_q            <= '0;
            samp_a            <= 1'b1;
            samp_b            <= 1'b1;
            pen_q             <= 1'b0;
            podd_q            <= 1'b0;
            pbit              <= 1'b0;
            perr              <= 1'b0;
            overrun           <= 1'b0;
            fifo.fifo_wr_en   <= 1'b0;
            fifo.fifo_wr_data <= '0;
        end else begin
            fifo.fifo_wr_en <= 1'b0;

            // Set wins over clear when both happen in one cycle.
            if (drop) begin
                overrun <= 1'b1;
            end else if (ovr_clr) begin
                overrun <= 1'b0;
            end

            if (state != IDLE && tick) begin
                scnt <= scnt + 1'b1;
                if (scnt == SCNT_W'(MID - 1)) samp_a <= rxs;
                if (scnt == SCNT_W'(MID))     samp_b <= rxs;
            end

            case (state)
                IDLE: begin
                    if (start_edge) begin
                        pen_q  <= parity_en;
                        podd_q <= parity_odd;
                        pbit   <= 1'b0;
                        perr   <= 1'b0;
                        scnt   <= '0;
                        state  <= START;
                    end
                end
                START: begin
                    if (decide) begin
                        if (samp_bit) begin
                            state <= IDLE;
                        end else begin
                            bcnt  <= '0;
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (decide) begin
                        // Shift in from the top so the first bit ends at bit 0.
                        data_q <= {samp_bit, data_q[c_DATA_BITS-1:1]};
                        bcnt   <= bcnt + 1'b1;
                        if (bcnt == 3'(c_DATA_BITS - 1)) begin
                            state <= pen_q ? PARITY : STOP;
                        end
                    end
                end
                PARITY: begin
                    if (decide) begin
                        pbit  <= samp_bit;
                        // Even parity wants an even count of ones over data+parity,
                        // odd parity wants an odd count.
                        perr  <= (^data_q) ^ samp_bit ^ podd_q;
                        state <= STOP;
                    end
                end
                STOP: begin
                    if (decide) begin
                        if (!fifo.fifo_wr_full) begin
                            fifo.fifo_wr_en   <= 1'b1;
                            fifo.fifo_wr_data <= word;
                        end
                        state <= samp_bit ? IDLE : WAIT_HIGH;
                    end
                end
                WAIT_HIGH: begin
                    if (rxs) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rx_busy   = (state != IDLE);
    assign state_dbg = state;

endmodule
